// File: rtl/ahb_slave_mux_ctrl_if.sv
// Bus bundle between the master-side sequencer, slaves 1..3 and the slave-mux controller.
// The master modport is the side that drives addresses and slave responses.
interface ahb_slave_mux_ctrl_if;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hsel_1;
  logic        hsel_2;
  logic        hsel_3;
  logic [31:0] hrdata_1;
  logic [31:0] hrdata_2;
  logic [31:0] hrdata_3;
  logic        hreadyout_1;
  logic        hreadyout_2;
  logic        hreadyout_3;
  logic        hresp_1;
  logic        hresp_2;
  logic        hresp_3;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresponse;

  modport master (
    output haddr, htrans,
    output hrdata_1, hrdata_2, hrdata_3,
    output hreadyout_1, hreadyout_2, hreadyout_3,
    output hresp_1, hresp_2, hresp_3,
    input  hsel_1, hsel_2, hsel_3,
    input  hrdata, hreadyout, hresponse
  );

  modport slave (
    input  haddr, htrans,
    input  hrdata_1, hrdata_2, hrdata_3,
    input  hreadyout_1, hreadyout_2, hreadyout_3,
    input  hresp_1, hresp_2, hresp_3,
    output hsel_1, hsel_2, hsel_3,
    output hrdata, hreadyout, hresponse
  );
endinterface

// File: rtl/ahb_slave_mux_ctrl.sv
// AHB-lite three-slave decoder and response mux with a built-in two-cycle ERROR default slave.
// Optional macro SLAVE_TIMEOUT_EN adds a wait-state watchdog that hands stuck transfers to the error FSM.
module ahb_slave_mux_ctrl #(
  parameter logic [3:0]  S1_BASE        = 4'h0,
  parameter logic [3:0]  S2_BASE        = 4'h1,
  parameter logic [3:0]  S3_BASE        = 4'h2,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  ahb_slave_mux_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    DSEL_NONE = 3'd0,
    DSEL_S1   = 3'd1,
    DSEL_S2   = 3'd2,
    DSEL_S3   = 3'd3,
    DSEL_DEF  = 3'd4
  } dsel_e;

  typedef enum logic [1:0] {
    ERR_IDLE = 2'd0,
    ERR_1    = 2'd1,
    ERR_2    = 2'd2
  } err_e;

  dsel_e       dsel_q;
  dsel_e       dsel_d;
  dsel_e       target_s;
  err_e        err_q;
  err_e        err_d;
  logic        hsel_1_s;
  logic        hsel_2_s;
  logic        hsel_3_s;
  logic [31:0] hrdata_s;
  logic        hready_s;
  logic        hresp_s;
  logic        unmapped_start_s;
  logic        timeout_s;
  logic        unused_s;

  assign unused_s = ^{bus.haddr[27:0], bus.htrans[0]};

  // Address-phase decode; rst forces all selects low
  always_comb begin
    target_s = DSEL_DEF;
    hsel_1_s = 1'b0;
    hsel_2_s = 1'b0;
    hsel_3_s = 1'b0;
    if (bus.haddr[31:28] == S1_BASE) begin
      target_s = DSEL_S1;
      hsel_1_s = ~rst_i;
    end else if (bus.haddr[31:28] == S2_BASE) begin
      target_s = DSEL_S2;
      hsel_2_s = ~rst_i;
    end else if (bus.haddr[31:28] == S3_BASE) begin
      target_s = DSEL_S3;
      hsel_3_s = ~rst_i;
    end else begin
      target_s = DSEL_DEF;
    end
  end

  assign bus.hsel_1 = hsel_1_s;
  assign bus.hsel_2 = hsel_2_s;
  assign bus.hsel_3 = hsel_3_s;

  // Response mux; an active error FSM overrides whichever owner holds the data phase
  always_comb begin
    hrdata_s = 32'h0;
    hready_s = 1'b1;
    hresp_s  = 1'b0;
    if (err_q != ERR_IDLE) begin
      hready_s = (err_q == ERR_2);
      hresp_s  = 1'b1;
    end else begin
      case (dsel_q)
        DSEL_S1: begin
          hrdata_s = bus.hrdata_1;
          hready_s = bus.hreadyout_1;
          hresp_s  = bus.hresp_1;
        end
        DSEL_S2: begin
          hrdata_s = bus.hrdata_2;
          hready_s = bus.hreadyout_2;
          hresp_s  = bus.hresp_2;
        end
        DSEL_S3: begin
          hrdata_s = bus.hrdata_3;
          hready_s = bus.hreadyout_3;
          hresp_s  = bus.hresp_3;
        end
        default: begin
          hrdata_s = 32'h0;
          hready_s = 1'b1;
          hresp_s  = 1'b0;
        end
      endcase
    end
  end

  assign bus.hrdata    = hrdata_s;
  assign bus.hreadyout = hready_s;
  assign bus.hresponse = hresp_s;

  // Data-phase owner follows the address phase only on a ready cycle
  always_comb begin
    dsel_d = dsel_q;
    if (hready_s) begin
      if (bus.htrans[1]) begin
        dsel_d = target_s;
      end else begin
        dsel_d = DSEL_NONE;
      end
    end else begin
      dsel_d = dsel_q;
    end
  end

  assign unmapped_start_s = hready_s & bus.htrans[1] & (target_s == DSEL_DEF);

  // Error FSM next state: two cycles per unmapped or timed-out transfer
  always_comb begin
    err_d = err_q;
    case (err_q)
      ERR_IDLE: begin
        if (unmapped_start_s || timeout_s) begin
          err_d = ERR_1;
        end else begin
          err_d = ERR_IDLE;
        end
      end
      ERR_1: err_d = ERR_2;
      ERR_2: begin
        if (unmapped_start_s) begin
          err_d = ERR_1;
        end else begin
          err_d = ERR_IDLE;
        end
      end
      default: err_d = ERR_IDLE;
    endcase
  end

  // Owner and error-FSM state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dsel_q <= DSEL_NONE;
      err_q  <= ERR_IDLE;
    end else begin
      dsel_q <= dsel_d;
      err_q  <= err_d;
    end
  end

`ifdef SLAVE_TIMEOUT_EN
  localparam int unsigned CNT_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 5) ? $clog2(TIMEOUT_CYCLES + 1) : 5;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             slave_ready_s;
  logic             stall_s;

  // Ready of the mapped slave owning the data phase (NONE/DEF never stall)
  always_comb begin
    slave_ready_s = 1'b1;
    case (dsel_q)
      DSEL_S1: slave_ready_s = bus.hreadyout_1;
      DSEL_S2: slave_ready_s = bus.hreadyout_2;
      DSEL_S3: slave_ready_s = bus.hreadyout_3;
      default: slave_ready_s = 1'b1;
    endcase
  end

  // A stall holds dsel, so any ready cycle or owner change clears the count
  assign stall_s = (err_q == ERR_IDLE) & ~slave_ready_s;

  // Wait-state counter; fires on the TIMEOUT_CYCLES-th consecutive stalled cycle
  always_comb begin
    cnt_d     = {CNT_W{1'b0}};
    timeout_s = 1'b0;
    if (stall_s) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        timeout_s = 1'b1;
        cnt_d     = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Wait-state counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic [31:0] unused_timeout_cfg_s;

  assign unused_timeout_cfg_s = 32'(TIMEOUT_CYCLES);
  assign timeout_s            = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_slave_mux_ctrl.sv
// Directed scoreboard bench for ahb_slave_mux_ctrl: per-cycle expectations queued by the
// stimulus and compared at the falling edge by a monitor.
module tb_ahb_slave_mux_ctrl;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  typedef struct {
    int          cyc;
    logic [2:0]  sel;
    logic [31:0] rdata;
    logic        rdy;
    logic        resp;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  ahb_slave_mux_ctrl_if bus ();

  ahb_slave_mux_ctrl #(
    .S1_BASE        (4'h0),
    .S2_BASE        (4'h1),
    .S3_BASE        (4'h2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic [1:0] t);
    bus.haddr  = a;
    bus.htrans = t;
  endtask

  task automatic set_slave(input int n, input logic [31:0] rd, input logic rdy, input logic resp);
    case (n)
      1: begin bus.hrdata_1 = rd; bus.hreadyout_1 = rdy; bus.hresp_1 = resp; end
      2: begin bus.hrdata_2 = rd; bus.hreadyout_2 = rdy; bus.hresp_2 = resp; end
      default: begin bus.hrdata_3 = rd; bus.hreadyout_3 = rdy; bus.hresp_3 = resp; end
    endcase
  endtask

  task automatic expect_now(input string tag, input logic [2:0] sel, input logic [31:0] rd,
                            input logic rdy, input logic resp);
    exp_t e;
    e.cyc   = cyc;
    e.sel   = sel;
    e.rdata = rd;
    e.rdy   = rdy;
    e.resp  = resp;
    e.tag   = tag;
    sb_q.push_back(e);
  endtask

  // Monitor: compare the expectation queued for this cycle
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
      mon_e = sb_q.pop_front();
      check({mon_e.tag, "_hsel"}, 64'({bus.hsel_3, bus.hsel_2, bus.hsel_1}), 64'(mon_e.sel));
      check({mon_e.tag, "_resp"}, 64'({bus.hrdata, bus.hreadyout, bus.hresponse}),
            64'({mon_e.rdata, mon_e.rdy, mon_e.resp}));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    addr_phase(32'h1000_0000, NONSEQ);
    set_slave(1, 32'd30, 1'b1, 1'b0);
    set_slave(2, 32'd40, 1'b1, 1'b0);
    set_slave(3, 32'd33, 1'b1, 1'b0);

    // reset with live-looking inputs
    tick(); expect_now("rst_a", 3'b000, 32'd0, 1'b1, 1'b0);
    tick(); addr_phase(32'h2000_0000, SEQ);
    expect_now("rst_b", 3'b000, 32'd0, 1'b1, 1'b0);
    tick(); addr_phase(32'hF000_0000, NONSEQ);
    expect_now("rst_c", 3'b000, 32'd0, 1'b1, 1'b0);
    tick(); rst = 1'b0; addr_phase(32'h0000_0000, IDLE);
    expect_now("post_rst_idle", 3'b001, 32'd0, 1'b1, 1'b0);
    tick(); addr_phase(32'hF000_0000, IDLE);
    expect_now("idle_unmapped_addr", 3'b000, 32'd0, 1'b1, 1'b0);

    // zero-wait read from slave 2
    tick(); addr_phase(32'h1000_0004, NONSEQ);
    expect_now("s2_addr", 3'b010, 32'd0, 1'b1, 1'b0);
    tick(); addr_phase(32'h0000_0000, IDLE);
    expect_now("s2_data", 3'b001, 32'd40, 1'b1, 1'b0);
    tick(); expect_now("s2_done", 3'b001, 32'd0, 1'b1, 1'b0);

    // BUSY to a mapped slave and IDLE to unmapped: OKAY, nothing forwarded
    tick(); addr_phase(32'h2000_0000, BUSY); set_slave(3, 32'd33, 1'b1, 1'b1);
    expect_now("busy_addr", 3'b100, 32'd0, 1'b1, 1'b0);
    tick(); addr_phase(32'hF000_0000, IDLE);
    expect_now("busy_data", 3'b000, 32'd0, 1'b1, 1'b0);
    tick(); addr_phase(32'h0000_0000, IDLE); set_slave(3, 32'd33, 1'b1, 1'b0);
    expect_now("idle_unm_data", 3'b001, 32'd0, 1'b1, 1'b0);

    // slave 1 with three wait states while the address bus moves on
    tick(); addr_phase(32'h0000_0010, NONSEQ); set_slave(1, 32'd30, 1'b0, 1'b0);
    expect_now("s1_addr", 3'b001, 32'd0, 1'b1, 1'b0);
    tick(); addr_phase(32'h1000_0000, NONSEQ);
    expect_now("s1_wait1", 3'b010, 32'd30, 1'b0, 1'b0);
    tick(); addr_phase(32'h2000_0000, NONSEQ);
    expect_now("s1_wait2", 3'b100, 32'd30, 1'b0, 1'b0);
    tick(); expect_now("s1_wait3", 3'b100, 32'd30, 1'b0, 1'b0);
    tick(); set_slave(1, 32'd30, 1'b1, 1'b0);
    expect_now("s1_data", 3'b100, 32'd30, 1'b1, 1'b0);
    tick(); addr_phase(32'h0000_0000, IDLE);
    expect_now("s3_after_wait", 3'b001, 32'd33, 1'b1, 1'b0);

    // unmapped transfer: default slave two-cycle ERROR
    tick(); addr_phase(32'hF000_0000, NONSEQ);
    expect_now("def_addr", 3'b000, 32'd0, 1'b1, 1'b0);
    tick(); addr_phase(32'h0000_0000, IDLE);
    expect_now("def_err1", 3'b001, 32'd0, 1'b0, 1'b1);
    tick(); expect_now("def_err2", 3'b001, 32'd0, 1'b1, 1'b1);
    tick(); expect_now("def_done", 3'b001, 32'd0, 1'b1, 1'b0);

    // back-to-back unmapped transfers: ERR_2 goes straight to ERR_1
    tick(); addr_phase(32'hF000_0000, NONSEQ);
    expect_now("b2b_def_addr", 3'b000, 32'd0, 1'b1, 1'b0);
    tick(); expect_now("b2b_err1a", 3'b000, 32'd0, 1'b0, 1'b1);
    tick(); addr_phase(32'hF000_0100, SEQ);
    expect_now("b2b_err2a", 3'b000, 32'd0, 1'b1, 1'b1);
    tick(); addr_phase(32'h0000_0000, IDLE);
    expect_now("b2b_err1b", 3'b001, 32'd0, 1'b0, 1'b1);
    tick(); expect_now("b2b_err2b", 3'b001, 32'd0, 1'b1, 1'b1);
    tick(); expect_now("b2b_done", 3'b001, 32'd0, 1'b1, 1'b0);

    // back-to-back mapped transfers, second one gets a slave ERROR
    tick(); addr_phase(32'h1000_0000, NONSEQ);
    expect_now("bb_s2_addr", 3'b010, 32'd0, 1'b1, 1'b0);
    tick(); addr_phase(32'h2000_0000, SEQ);
    expect_now("bb_s2_data", 3'b100, 32'd40, 1'b1, 1'b0);
    tick(); addr_phase(32'h0000_0000, IDLE); set_slave(3, 32'd33, 1'b0, 1'b1);
    expect_now("s3_err1", 3'b001, 32'd33, 1'b0, 1'b1);
    tick(); set_slave(3, 32'd33, 1'b1, 1'b1);
    expect_now("s3_err2", 3'b001, 32'd33, 1'b1, 1'b1);
    tick(); set_slave(3, 32'd33, 1'b1, 1'b0);
    expect_now("s3_done", 3'b001, 32'd0, 1'b1, 1'b0);

    // reset asserted in the middle of a wait state
    tick(); addr_phase(32'h0000_0000, NONSEQ); set_slave(1, 32'd30, 1'b0, 1'b0);
    expect_now("rw_addr", 3'b001, 32'd0, 1'b1, 1'b0);
    tick(); addr_phase(32'h0000_0000, IDLE);
    expect_now("rw_wait", 3'b001, 32'd30, 1'b0, 1'b0);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("rw_async_hsel", 64'({bus.hsel_3, bus.hsel_2, bus.hsel_1}), 64'(3'b000));
    check("rw_async_resp", 64'({bus.hrdata, bus.hreadyout, bus.hresponse}), 64'({32'd0, 1'b1, 1'b0}));
    tick(); set_slave(1, 32'd30, 1'b1, 1'b0);
    expect_now("rw_in_rst", 3'b000, 32'd0, 1'b1, 1'b0);
    tick(); rst = 1'b0;
    expect_now("rw_after", 3'b001, 32'd0, 1'b1, 1'b0);

    // slave 3 stuck not-ready
    tick(); addr_phase(32'h2000_0000, NONSEQ); set_slave(3, 32'd33, 1'b0, 1'b0);
    expect_now("to_addr", 3'b100, 32'd0, 1'b1, 1'b0);
    tick(); addr_phase(32'h0000_0000, IDLE);
    expect_now("to_wait", 3'b001, 32'd33, 1'b0, 1'b0);
    for (int i = 1; i < 16; i++) begin
      tick(); expect_now("to_wait", 3'b001, 32'd33, 1'b0, 1'b0);
    end
`ifdef SLAVE_TIMEOUT_EN
    tick(); expect_now("to_err1", 3'b001, 32'd0, 1'b0, 1'b1);
    tick(); expect_now("to_err2", 3'b001, 32'd0, 1'b1, 1'b1);
    tick(); set_slave(3, 32'd33, 1'b1, 1'b0);
    expect_now("to_done", 3'b001, 32'd0, 1'b1, 1'b0);
`else
    for (int i = 0; i < 4; i++) begin
      tick(); expect_now("to_persist", 3'b001, 32'd33, 1'b0, 1'b0);
    end
    tick(); set_slave(3, 32'd33, 1'b1, 1'b0);
    expect_now("to_release", 3'b001, 32'd33, 1'b1, 1'b0);
    tick(); expect_now("to_done", 3'b001, 32'd0, 1'b1, 1'b0);
`endif

    tick();
    tick();
    check("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
